axis_rr_frame_arbiter: RTL and testbench

- Frame-granular round-robin arbiter and mux that shares one AXI-stream FIFO input, such as the async FIFO width adapter's s_axis side, between S_COUNT requesters.
- A grant is held from the first beat to the tlast beat of a frame, so frames are never interleaved.
- The source index is stamped on m_axis_tid so a downstream block can demultiplex.
- Sits in the s_clk domain, directly ahead of the FIFO.

---
 rtl/axis_rr_frame_arbiter.sv | 146 ++++++++++++++
 tb/tb_axis_rr_frame_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_frame_arbiter.sv
// Frame-granular round-robin AXI-stream arbiter and mux with one output register stage.
// A grant is held from the first beat through tlast; the source index is carried on m_axis_tid.
module axis_rr_frame_arbiter #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int CL_S_COUNT  = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [CL_S_COUNT-1:0]         m_axis_tid,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          grant_valid,
    output logic [CL_S_COUNT-1:0]         grant_index
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_reg, state_next;
    logic [CL_S_COUNT-1:0]   grant_index_reg, grant_index_next;
    logic [CL_S_COUNT-1:0]   last_grant_reg, last_grant_next;
    logic [CL_S_COUNT-1:0]   sel;
    logic [CL_S_COUNT-1:0]   cand;
    logic                    found;

    logic [DATA_WIDTH-1:0]   tdata_arr [S_COUNT];
    logic [KEEP_WIDTH-1:0]   tkeep_arr [S_COUNT];
    logic [USER_WIDTH-1:0]   tuser_arr [S_COUNT];

    logic [DATA_WIDTH-1:0]   m_axis_tdata_reg;
    logic [KEEP_WIDTH-1:0]   m_axis_tkeep_reg;
    logic                    m_axis_tvalid_reg;
    logic                    m_axis_tlast_reg;
    logic [CL_S_COUNT-1:0]   m_axis_tid_reg;
    logic [USER_WIDTH-1:0]   m_axis_tuser_reg;

    logic                    out_ready;
    logic                    in_xfer;
    logic                    in_last;

    // The output stage can take a beat when it is empty or being drained this cycle.
    assign out_ready = !m_axis_tvalid_reg || m_axis_tready;
    assign in_xfer   = (state_reg == BUSY) && s_axis_tvalid[grant_index_reg] && out_ready;
    assign in_last   = s_axis_tlast[grant_index_reg];

    generate
        for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_stream
            assign tdata_arr[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign tkeep_arr[gi] = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
            assign tuser_arr[gi] = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
            assign s_axis_tready[gi] = (state_reg == BUSY) &&
                                       (grant_index_reg == CL_S_COUNT'(gi)) && out_ready;
        end
    endgenerate

    // Round-robin search starting just above the previous winner.
    always_comb begin
        sel   = last_grant_reg;
        cand  = last_grant_reg;
        found = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            cand = (cand == CL_S_COUNT'(S_COUNT - 1)) ? '0 : cand + 1'b1;
            if (!found && s_axis_tvalid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_index_next = grant_index_reg;
        last_grant_next  = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    state_next       = BUSY;
                    grant_index_next = sel;
                    last_grant_next  = sel;
                end
            end
            BUSY: begin
                if (in_xfer && in_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_index_reg <= '0;
            last_grant_reg  <= CL_S_COUNT'(S_COUNT - 1);
        end else begin
            state_reg       <= state_next;
            grant_index_reg <= grant_index_next;
            last_grant_reg  <= last_grant_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata_reg  <= '0;
            m_axis_tkeep_reg  <= '0;
            m_axis_tvalid_reg <= 1'b0;
            m_axis_tlast_reg  <= 1'b0;
            m_axis_tid_reg    <= '0;
            m_axis_tuser_reg  <= '0;
        end else if (in_xfer) begin
            m_axis_tdata_reg  <= tdata_arr[grant_index_reg];
            m_axis_tkeep_reg  <= tkeep_arr[grant_index_reg];
            m_axis_tvalid_reg <= 1'b1;
            m_axis_tlast_reg  <= in_last;
            m_axis_tid_reg    <= grant_index_reg;
            m_axis_tuser_reg  <= tuser_arr[grant_index_reg];
        end else if (m_axis_tready) begin
            m_axis_tvalid_reg <= 1'b0;
        end
    end

    assign m_axis_tdata  = m_axis_tdata_reg;
    assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? m_axis_tkeep_reg : '1;
    assign m_axis_tvalid = m_axis_tvalid_reg;
    assign m_axis_tlast  = m_axis_tlast_reg;
    assign m_axis_tid    = m_axis_tid_reg;
    assign m_axis_tuser  = (USER_ENABLE != 0) ? m_axis_tuser_reg : '0;
    assign grant_valid   = (state_reg == BUSY);
    assign grant_index   = grant_index_reg;

endmodule

// File: tb/tb_axis_rr_frame_arbiter.sv
// Bench for axis_rr_frame_arbiter: AXI-compliant random sources, frame-level round-robin
// reference model and an in-order beat scoreboard, plus directed scenarios.
module tb_axis_rr_frame_arbiter;

    localparam int S_COUNT = 4;
    localparam int DW      = 8;
    localparam int KW      = 1;
    localparam int UW      = 1;
    localparam int CL      = 2;
    localparam int MAXLEN  = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [S_COUNT*DW-1:0] s_axis_tdata;
    logic [S_COUNT*KW-1:0] s_axis_tkeep;
    logic [S_COUNT-1:0]    s_axis_tvalid;
    logic [S_COUNT-1:0]    s_axis_tready;
    logic [S_COUNT-1:0]    s_axis_tlast;
    logic [S_COUNT*UW-1:0] s_axis_tuser;
    logic [DW-1:0]         m_axis_tdata;
    logic [KW-1:0]         m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [CL-1:0]         m_axis_tid;
    logic [UW-1:0]         m_axis_tuser;
    logic                  grant_valid;
    logic [CL-1:0]         grant_index;

    always #5 clk = ~clk;

    axis_rr_frame_arbiter #(
        .S_COUNT    (S_COUNT),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tuser  (m_axis_tuser),
        .grant_valid   (grant_valid),
        .grant_index   (grant_index)
    );

    typedef struct packed {
        logic [CL-1:0] id;
        logic [DW-1:0] data;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    int checks   = 0;
    int failures = 0;

    // Source state: one frame in flight per stream, auto-refilled while src_refill > 0.
    logic [DW-1:0] src_data [S_COUNT][MAXLEN];
    logic [UW-1:0] src_user [S_COUNT][MAXLEN];
    int src_len      [S_COUNT];
    int src_pos      [S_COUNT];
    int src_refill   [S_COUNT];
    int src_hold     [S_COUNT];
    int src_hold_pos [S_COUNT];
    int src_hold_len [S_COUNT];
    logic [S_COUNT-1:0] vld;
    int gap_pct    = 0;
    int ready_pct  = 100;
    int ready_mode = 0;
    int fixed_len  = 0;
    int cyc        = 0;

    // Reference model: frame-level round robin plus expected output beats in order.
    bit    mdl_busy;
    int    mdl_owner;
    int    mdl_last;
    bit    chk_reset;
    beat_t exp_q[$];
    int    win_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < S_COUNT; i++) begin
            s_axis_tdata[i*DW +: DW] = (src_len[i] != 0) ? src_data[i][src_pos[i]] : '0;
            s_axis_tuser[i*UW +: UW] = (src_len[i] != 0) ? src_user[i][src_pos[i]] : '0;
            s_axis_tkeep[i*KW +: KW] = KW'($urandom_range(1));
            s_axis_tlast[i] = (src_len[i] != 0) && (src_pos[i] == src_len[i] - 1);
        end
        s_axis_tvalid = vld;
    endtask

    task automatic new_frame(input int i, input int len, input int base);
        src_len[i] = len;
        src_pos[i] = 0;
        for (int b = 0; b < len; b++) begin
            src_data[i][b] = DW'(base + b);
            src_user[i][b] = UW'($urandom_range(1));
        end
    endtask

    task automatic load(input int i, input int len, input int base);
        new_frame(i, len, base);
        vld[i] = 1'b1;
        drive_inputs();
    endtask

    task automatic model_reset();
        mdl_busy  = 1'b0;
        mdl_owner = 0;
        mdl_last  = S_COUNT - 1;
        exp_q.delete();
        win_q.delete();
        for (int i = 0; i < S_COUNT; i++) begin
            src_len[i]      = 0;
            src_pos[i]      = 0;
            src_refill[i]   = 0;
            src_hold[i]     = 0;
            src_hold_pos[i] = -1;
            src_hold_len[i] = 0;
        end
    endtask

    task automatic eval_cycle(output logic [S_COUNT-1:0] hs);
        int occ;
        int w;
        int c;
        logic [S_COUNT-1:0] om;
        beat_t e;
        hs = '0;
        if (rst) begin
            model_reset();
            chk_reset = 1'b1;
            return;
        end
        if (chk_reset) begin
            chk_reset = 1'b0;
            check("rst_m_tvalid", m_axis_tvalid, 0);
            check("rst_m_tlast", m_axis_tlast, 0);
            check("rst_m_tid", m_axis_tid, 0);
            check("rst_m_tdata", m_axis_tdata, 0);
            check("rst_m_tuser", m_axis_tuser, 0);
            check("rst_grant_valid", grant_valid, 0);
            check("rst_grant_index", grant_index, 0);
            check("rst_s_tready", s_axis_tready, 0);
        end
        occ = exp_q.size();
        check("m_tvalid", m_axis_tvalid, occ != 0);
        if (occ != 0) begin
            e = exp_q[0];
            if (m_axis_tvalid) begin
                check("m_tid", m_axis_tid, e.id);
                check("m_tdata", m_axis_tdata, e.data);
                check("m_tlast", m_axis_tlast, e.last);
                check("m_tuser", m_axis_tuser, e.user);
                check("m_tkeep", m_axis_tkeep, {KW{1'b1}});
            end
            if (m_axis_tready) begin
                $display("beat tid=%0d data=%02h last=%0d user=%0d", e.id, e.data, e.last, e.user);
                void'(exp_q.pop_front());
            end
        end
        if (!mdl_busy) begin
            check("idle_grant_valid", grant_valid, 0);
            check("idle_s_tready", s_axis_tready, 0);
            w = -1;
            for (int k = 1; k <= S_COUNT; k++) begin
                c = (mdl_last + k) % S_COUNT;
                if (w < 0 && vld[c]) w = c;
            end
            if (w >= 0) begin
                mdl_busy  = 1'b1;
                mdl_owner = w;
                mdl_last  = w;
                win_q.push_back(w);
            end
        end else begin
            check("grant_valid", grant_valid, 1);
            check("grant_index", grant_index, mdl_owner);
            om = '0;
            om[mdl_owner] = 1'b1;
            check("other_s_tready", s_axis_tready & ~om, 0);
            check("own_s_tready", s_axis_tready[mdl_owner], (occ == 0) || m_axis_tready);
            if (vld[mdl_owner] && s_axis_tready[mdl_owner]) begin
                hs[mdl_owner] = 1'b1;
                e.id   = CL'(mdl_owner);
                e.data = src_data[mdl_owner][src_pos[mdl_owner]];
                e.user = src_user[mdl_owner][src_pos[mdl_owner]];
                e.last = (src_pos[mdl_owner] == src_len[mdl_owner] - 1);
                exp_q.push_back(e);
                if (e.last) mdl_busy = 1'b0;
            end
        end
    endtask

    task automatic update_sources(input logic [S_COUNT-1:0] hs);
        for (int i = 0; i < S_COUNT; i++) begin
            if (hs[i]) begin
                src_pos[i]++;
                if (src_pos[i] == src_hold_pos[i]) src_hold[i] = src_hold_len[i];
                if (src_pos[i] >= src_len[i]) begin
                    src_len[i] = 0;
                    src_pos[i] = 0;
                end
            end
            if (src_len[i] == 0 && src_refill[i] > 0) begin
                new_frame(i, (fixed_len != 0) ? fixed_len : int'($urandom_range(MAXLEN, 1)),
                          int'($urandom_range(255)));
                src_refill[i]--;
            end
            // A valid beat must stay offered until it is taken.
            if (src_len[i] == 0) vld[i] = 1'b0;
            else if (vld[i] && !hs[i]) vld[i] = 1'b1;
            else if (src_hold[i] > 0) begin
                vld[i] = 1'b0;
                src_hold[i]--;
            end else vld[i] = ($urandom_range(99) >= gap_pct);
        end
        m_axis_tready = (ready_mode != 0) ? (cyc % 3 == 0) : ($urandom_range(99) < ready_pct);
        drive_inputs();
    endtask

    task automatic step();
        logic [S_COUNT-1:0] hs;
        @(negedge clk);
        eval_cycle(hs);
        @(posedge clk);
        #1;
        cyc++;
        update_sources(hs);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic bit all_idle();
        bit r = (vld == '0) && (exp_q.size() == 0) && !mdl_busy;
        for (int i = 0; i < S_COUNT; i++)
            if (src_len[i] != 0 || src_refill[i] != 0) r = 1'b0;
        return r;
    endfunction

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!all_idle() && n < budget);
        check(tag, all_idle(), 1);
    endtask

    function automatic int win_at(input int k);
        return (k < win_q.size()) ? win_q[k] : -1;
    endfunction

    initial begin
        int n;
        int total;
        vld = '0;
        m_axis_tready = 1'b1;
        model_reset();
        chk_reset = 1'b0;
        drive_inputs();
        do_reset();

        // Single 3-beat frame on stream 2.
        load(2, 3, 8'hA1);
        run_until_done("t1_drain", 200);
        check("t1_frames", win_q.size(), 1);
        check("t1_winner", win_at(0), 2);

        // All streams continuously offering 2-beat frames.
        do_reset();
        fixed_len = 2;
        for (int i = 0; i < S_COUNT; i++) begin
            load(i, 2, 16 * (i + 1));
            src_refill[i] = 2;
        end
        run_until_done("t2_drain", 500);
        check("t2_frames", win_q.size(), 12);
        for (int k = 0; k < 12; k++) check("t2_order", win_at(k), k % S_COUNT);
        fixed_len = 0;

        // Streams 1 and 3 with last grant 3.
        do_reset();
        load(1, 3, 8'h31);
        load(3, 2, 8'h33);
        run_until_done("t3_drain", 200);
        check("t3_first", win_at(0), 1);
        check("t3_second", win_at(1), 3);

        // Backpressure pattern on a 4-beat stream 0 frame.
        do_reset();
        ready_mode = 1;
        load(0, 4, 8'h40);
        run_until_done("t4_drain", 200);
        ready_mode = 0;
        check("t4_winner", win_at(0), 0);

        // Stream 1 stalls 5 cycles mid-frame while stream 2 waits.
        do_reset();
        src_hold_pos[1] = 2;
        src_hold_len[1] = 5;
        load(1, 4, 8'h50);
        load(2, 2, 8'h60);
        run_until_done("t5_drain", 200);
        check("t5_first", win_at(0), 1);
        check("t5_second", win_at(1), 2);

        // Reset after beat 2 of a 4-beat frame on stream 3.
        do_reset();
        load(3, 4, 8'h70);
        n = 0;
        while (src_pos[3] != 2 && n < 50) begin
            step();
            n++;
        end
        check("t6_reach_beat2", src_pos[3], 2);
        do_reset();
        load(0, 2, 8'h80);
        load(3, 2, 8'h90);
        run_until_done("t6_drain", 200);
        check("t6_first", win_at(0), 0);
        check("t6_second", win_at(1), 3);

        // Random traffic: source gaps, random lengths, random output backpressure.
        do_reset();
        gap_pct   = 30;
        ready_pct = 60;
        total     = 0;
        for (int i = 0; i < S_COUNT; i++) begin
            src_refill[i] = $urandom_range(6, 3);
            total += src_refill[i];
        end
        run_until_done("t7_drain", 5000);
        check("t7_frames", win_q.size(), total);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
